// File: rtl/adder64_arb.sv
// Shares one 64-bit adder among NUM_REQ valid/ready requesters with a single-entry result slot.
// Define ADD64_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.

module adder64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sum_o,
    output logic        carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

module adder64_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*64-1:0]   req_a,
    input  logic [NUM_REQ*64-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [63:0]             rsp_sum,
    output logic                    rsp_carry,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);
    logic                          rsp_valid_q, rsp_valid_d;
    logic [63:0]                   sum_q, sum_d;
    logic                          carry_q, carry_d;
    logic [ID_W-1:0]               id_q, id_d;
    logic [NUM_REQ-1:0][ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]               win_id;
    logic                          win_vld;
    logic                          slot_free;
    logic                          accept;
    logic [63:0]                   op_a, op_b, add_sum;
    logic                          add_carry;

    // scan_idx[k] is the requester with k-th highest priority this cycle
`ifdef ADD64_ARB_FIXED_PRIO_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_scan
        assign scan_idx[k] = ID_W'(k);
    end
`else
    logic [ID_W-1:0] ptr_q, ptr_d;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_scan
        assign scan_idx[k] = ID_W'((int'(ptr_q) + k) % NUM_REQ);
    end
`endif

    always_comb begin
        win_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[scan_idx[k]]) win_id = scan_idx[k];
        end
    end

    assign win_vld   = |req_valid;
    assign slot_free = ~rsp_valid_q | rsp_ready;
    assign accept    = rst_n & slot_free & win_vld;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
        assign req_ready[i] = rst_n & slot_free & req_valid[i] & (win_id == ID_W'(i));
    end

    assign op_a = req_a[{win_id, 6'd0} +: 64];
    assign op_b = req_b[{win_id, 6'd0} +: 64];

    adder64 u_add (
        .a_i     (op_a),
        .b_i     (op_b),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        id_d        = id_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            sum_d       = add_sum;
            carry_d     = add_carry;
            id_d        = win_id;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            id_q        <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            id_q        <= id_d;
        end
    end

`ifndef ADD64_ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (accept)
            ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(win_id + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;
    assign busy      = rsp_valid_q | (|req_valid);
endmodule

// File: tb/tb_adder64_arb.sv
// Directed-vector bench for adder64_arb (NUM_REQ=4); expectations track ADD64_ARB_FIXED_PRIO_EN.

module tb_adder64_arb;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_a;
    logic [NUM_REQ*64-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_sum;
    logic                  rsp_carry;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    int n_chk  = 0;
    int n_fail = 0;

    adder64_arb #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
        req_valid[i]      = 1'b1;
    endtask

    // inputs change 1ns after the rising edge; outputs are sampled before the next one
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // reset state, with a request already pending to check ready gating
        req_valid = 4'b0100;
        #23;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_sum",   rsp_sum,        64'd0);

        // 1: single requester
        req_valid = '0;
        set_req(2, 64'h0000_0001_FFFF_FFFF, 64'd1);
        rst_n = 1'b1;
        #1;
        chk("t1_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        chk("t1_valid", 64'(rsp_valid), 64'd1);
        chk("t1_sum",   rsp_sum,        64'h0000_0002_0000_0000);
        chk("t1_carry", 64'(rsp_carry), 64'd0);
        chk("t1_id",    64'(rsp_id),    64'd2);

        // 2: carry out
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        tick();
        chk("t2a_sum",   rsp_sum,        64'd0);
        chk("t2a_carry", 64'(rsp_carry), 64'd1);
        chk("t2a_id",    64'(rsp_id),    64'd0);
        set_req(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        tick();
        req_valid = '0;
        chk("t2b_sum",   rsp_sum,        64'd0);
        chk("t2b_carry", 64'(rsp_carry), 64'd1);

        // 3: rotation from a fresh pointer
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'(i), 64'd100);
        for (int n = 0; n < 5; n++) begin
            tick();
`ifdef ADD64_ARB_FIXED_PRIO_EN
            chk($sformatf("t3_id%0d", n),  64'(rsp_id), 64'd0);
            chk($sformatf("t3_sum%0d", n), rsp_sum,     64'd100);
`else
            chk($sformatf("t3_id%0d", n),  64'(rsp_id), 64'(n % NUM_REQ));
            chk($sformatf("t3_sum%0d", n), rsp_sum,     64'(100 + n % NUM_REQ));
`endif
        end
        req_valid = '0;

        // 4: backpressure
        tick();
        chk("t4_drained", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;
        set_req(1, 64'h10, 64'h1);
        set_req(3, 64'h30, 64'h3);
        #1;
        chk("t4_first_ready", 64'(req_ready), 64'b0010);
        tick();
        set_req(1, 64'h20, 64'h2);
        chk("t4_acc_id",  64'(rsp_id), 64'd1);
        chk("t4_acc_sum", rsp_sum,     64'h11);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("t4_stall_ready%0d", n), 64'(req_ready), 64'd0);
            chk($sformatf("t4_stall_sum%0d", n),   rsp_sum,        64'h11);
            tick();
        end
        chk("t4_stall_id", 64'(rsp_id), 64'd1);
        rsp_ready = 1'b1;
        #1;
`ifdef ADD64_ARB_FIXED_PRIO_EN
        chk("t4_resume_ready", 64'(req_ready), 64'b0010);
        tick();
        chk("t4_resume_id",  64'(rsp_id), 64'd1);
        chk("t4_resume_sum", rsp_sum,     64'h22);
`else
        chk("t4_resume_ready", 64'(req_ready), 64'b1000);
        tick();
        chk("t4_resume_id",  64'(rsp_id), 64'd3);
        chk("t4_resume_sum", rsp_sum,     64'h33);
`endif
        chk("t4_no_bubble", 64'(rsp_valid), 64'd1);

        // 5: async reset while the slot is stalled
        rsp_ready = 1'b0;
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(rsp_valid), 64'd0);
        chk("t5_sum",   rsp_sum,        64'd0);
        chk("t5_id",    64'(rsp_id),    64'd0);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'(i), 64'd100);
        #1;
        chk("t5_first_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        chk("t5_first_id", 64'(rsp_id), 64'd0);
        chk("t5_busy_hi",  64'(busy),   64'd1);

        // 6: empty cycles, then wrap 3 -> 0
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("t6_busy%0d", n), 64'(busy), 64'd0);
        end
        chk("t6_drop_valid", 64'(rsp_valid), 64'd0);
        chk("t6_hold_sum",   rsp_sum,        64'd100);
        set_req(3, 64'd7, 64'd8);
        set_req(0, 64'd1, 64'd1);
        tick();
`ifdef ADD64_ARB_FIXED_PRIO_EN
        chk("t6_first_id",  64'(rsp_id), 64'd0);
        chk("t6_first_sum", rsp_sum,     64'd2);
`else
        chk("t6_first_id",  64'(rsp_id), 64'd3);
        chk("t6_first_sum", rsp_sum,     64'd15);
`endif
        req_valid = '0;
        set_req(0, 64'd1, 64'd1);
        set_req(1, 64'd5, 64'd5);
        tick();
        req_valid = '0;
        chk("t6_wrap_id",  64'(rsp_id), 64'd0);
        chk("t6_wrap_sum", rsp_sum,     64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
